// File: rtl/bcd_converter_pkg.sv
// Shared definitions for the decimal display path: converter state encoding and
// the double-dabble digit correction constants.
package bcd_converter_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_SHIFT = 1'b1;

    typedef enum logic {
        StIdle  = STATE_IDLE,
        StShift = STATE_SHIFT
    } bcd_state_e;

    // A digit at or above the threshold would exceed 9 after doubling, so it is
    // pre-corrected by adding 3 before the shift.
    localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;
    localparam logic [3:0] BCD_ADJUST_ADD       = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble correction for one BCD digit: if >= 5, add 3.
module bcd_digit_adjust
    import bcd_converter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJUST_THRESHOLD) begin
            digit_o = digit_i + BCD_ADJUST_ADD;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Result and overflow flag are held between conversions.
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 16,
    parameter int unsigned DIGITS      = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INPUT_WIDTH-1:0] binary,
    output logic                   busy,
    output logic                   done,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   overflow
);

    localparam int unsigned CntW = $clog2(INPUT_WIDTH + 1);
    localparam int unsigned ScrW = 4 * DIGITS;

    bcd_state_e             state_q, state_d;
    logic [INPUT_WIDTH-1:0] shift_q, shift_d;
    logic [ScrW-1:0]        scratch_q, scratch_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   sticky_q, sticky_d;
    logic [ScrW-1:0]        bcd_q, bcd_d;
    logic                   overflow_q, overflow_d;
    logic                   done_q, done_d;

    logic [ScrW-1:0]        adjusted;
    logic [ScrW-1:0]        scratch_shifted;
    logic [INPUT_WIDTH-1:0] shift_shifted;
    logic                   carry_out;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (adjusted[4*g +: 4])
        );
    end

    // Bit leaving the top digit carries 10^DIGITS, so it can only mean overflow.
    always_comb begin
        carry_out       = adjusted[ScrW-1];
        scratch_shifted = {adjusted[ScrW-2:0], shift_q[INPUT_WIDTH-1]};
        shift_shifted   = {shift_q[INPUT_WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = binary;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CntW'(INPUT_WIDTH);
                    state_d   = StShift;
                end
            end
            StShift: begin
                scratch_d = scratch_shifted;
                shift_d   = shift_shifted;
                sticky_d  = sticky_q | carry_out;
                cnt_d     = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bcd_d      = scratch_shifted;
                    overflow_d = sticky_q | carry_out;
                    done_d     = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        busy     = (state_q == StShift);
        done     = done_q;
        bcd      = bcd_q;
        overflow = overflow_q;
    end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
Sequential binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) method. It sits directly upstream of the seven-segment controller. It takes the raw 16-bit switch value and produces packed BCD digits for the controller's data input, so the display shows decimal instead of hex. It processes one input bit per clock and holds its result stable between conversions.

Parameters:
INPUT_WIDTH, 16, width of binary input; number of shift iterations per conversion
DIGITS, 4, number of BCD output digits (4 bits each); must match controller DIGITS

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  request conversion of binary; sampled on posedge clock
binary  input  INPUT_WIDTH  unsigned value to convert; sampled only when start is accepted
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when bcd/overflow are updated
bcd  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; held until next done
overflow  output  1  result >= 10^DIGITS; held with bcd

Behaviour:
- Reset: asynchronous, active-high; clock is clock. On reset: state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal scratch/shift/counter registers=0. Reset mid-conversion aborts it, with no done pulse and no result update.
- States: IDLE, SHIFT.
- IDLE: if start=1 at edge k, then latch binary into shift register, clear scratch digits and sticky overflow, load counter=INPUT_WIDTH, busy<=1, go to SHIFT. Otherwise hold.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (combinational, all digits in parallel).
  - Then shift {scratch, shift_reg} left by one; the shift_reg MSB enters scratch bit 0.
  - If the bit shifted out of the top scratch digit is 1, set sticky overflow.
  - Decrement counter.
- Last SHIFT edge (counter==1, edge k+INPUT_WIDTH):
  - bcd <= final scratch; overflow <= sticky flag.
  - done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency: start accepted at edge k, result visible and done high after edge k+INPUT_WIDTH (16 cycles default). Back-to-back throughput is one conversion per INPUT_WIDTH+1 cycles. start in the done cycle is accepted, because state is already IDLE.
- start while busy=1 is ignored; no queueing. Changes on binary during SHIFT have no effect.
- Overflow: bcd holds value mod 10^DIGITS (the lower digits are unaffected by the discarded carry) and overflow=1.
- done and busy are never simultaneously high.
- Counter width: clog2(INPUT_WIDTH+1) bits. Scratch width: 4*DIGITS bits.

Decomposition:
- Shared header: localparams for state encodings (IDLE=1'b0, SHIFT=1'b1) and BCD_ADJUST_THRESHOLD=5, BCD_ADJUST_ADD=3, shared with future decimal display blocks.
- One sub-module: bcd_digit_adjust. It is a combinational 4-bit "if >=5 add 3", instantiated DIGITS times via generate.

Test Plan:
- Reset then idle -> bcd=16'h0000, overflow=0, busy=0, done=0; no done pulse for 50 cycles without start.
- start=1 one cycle, binary=16'd1234 -> busy high 16 cycles, then done pulse for 1 cycle; bcd=16'h1234, overflow=0.
- Boundary values, each with a separate start:
  - binary=0 -> bcd=16'h0000, overflow=0.
  - binary=9999 -> bcd=16'h9999, overflow=0.
  - binary=10000 -> bcd=16'h0000, overflow=1.
  - binary=65535 -> bcd=16'h5535, overflow=1.
- Conversion of 42 in progress; at cycle 5 assert start with binary=777 -> second start ignored; result bcd=16'h0042 after 16 cycles. Then start in the done cycle with 777 -> accepted; bcd=16'h0777 16 cycles later.
- start with 4321; assert reset at cycle 8 -> busy=0, bcd=0 immediately and asynchronously; no done pulse follows. Next start with 8 -> bcd=16'h0008.
- Random sweep of 1000 values against a reference model (value mod 10000 digits, overflow=value>9999) -> all match, done count=start-accepted count.
